sramx_arbiter: RTL and testbench

//  Multi-channel SRAM-like bus bridge/arbiter. Merges NCH core request channels (I-bus, D-bus, ...)

---
 rtl/sramx_arbiter.sv | 119 +++++++++++
 tb/tb_sramx_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sramx_arbiter.sv
// rtl/sramx_arbiter.sv - multi-channel SRAM-like bus arbiter with kseg0/kseg1 translation
// Round-robin issue to one pipelined SRAM port; responses return in issue order via a tag pipe.
module sramx_arbiter #(
   parameter int NCH        = 2,
   parameter int LATENCY    = 1,
   parameter int MAX_OUT    = 2,
   parameter int ADDR_TRANS = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH*4-1:0]  ch_wen,
   input  logic [NCH*32-1:0] ch_addr,
   input  logic [NCH*32-1:0] ch_wdata,
   output logic [NCH-1:0]    ch_addr_ok,
   output logic [NCH-1:0]    ch_data_ok,
   output logic [31:0]       ch_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_wen,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [CW-1:0]      rr_q, rr_d;
   logic [2:0]         cnt_q [NCH];
   logic [LATENCY-1:0] vld_q;
   logic [LATENCY-1:0] twr_q;
   logic [CW-1:0]      tch_q [LATENCY];

   logic               gnt;
   logic [CW-1:0]      gidx;
   logic [NCH-1:0]     elig;
   logic [NCH-1:0]     resp;
   int                 idx;

   function automatic logic [31:0] xlate(input logic [31:0] a);
      if (ADDR_TRANS != 0 && a[31:30] == 2'b10)
         return {3'b000, a[28:0]};
      return a;
   endfunction

   // A response retiring this cycle frees its slot, so the channel can be regranted at once.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         resp[i] = vld_q[LATENCY-1] && (tch_q[LATENCY-1] == CW'(i));
         elig[i] = resetn && ch_req[i] &&
                   ((cnt_q[i] - {2'b00, resp[i]}) < 3'(MAX_OUT));
      end
   end

   always_comb begin
      gnt  = 1'b0;
      gidx = '0;
      idx  = 0;
      for (int k = 0; k < NCH; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NCH)
            idx = idx - NCH;
         if (!gnt && elig[idx]) begin
            gnt  = 1'b1;
            gidx = CW'(idx);
         end
      end
   end

   always_comb begin
      mem_en     = gnt;
      mem_wen    = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      ch_addr_ok = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt && gidx == CW'(i)) begin
            ch_addr_ok[i] = 1'b1;
            mem_wen       = ch_wen[4*i +: 4];
            mem_addr      = xlate(ch_addr[32*i +: 32]);
            mem_wdata     = ch_wdata[32*i +: 32];
         end
      end
      rr_d = rr_q;
      if (gnt)
         rr_d = (gidx == CW'(NCH-1)) ? '0 : gidx + CW'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_q  <= '0;
         vld_q <= '0;
         twr_q <= '0;
         for (int s = 0; s < LATENCY; s++)
            tch_q[s] <= '0;
         for (int i = 0; i < NCH; i++)
            cnt_q[i] <= '0;
      end else begin
         rr_q     <= rr_d;
         vld_q[0] <= gnt;
         tch_q[0] <= gidx;
         twr_q[0] <= |mem_wen;
         for (int s = LATENCY-1; s > 0; s--) begin
            vld_q[s] <= vld_q[s-1];
            tch_q[s] <= tch_q[s-1];
            twr_q[s] <= twr_q[s-1];
         end
         for (int i = 0; i < NCH; i++) begin
            case ({ch_addr_ok[i], resp[i]})
               2'b10:   cnt_q[i] <= cnt_q[i] + 3'd1;
               2'b01:   cnt_q[i] <= cnt_q[i] - 3'd1;
               default: cnt_q[i] <= cnt_q[i];
            endcase
         end
      end
   end

   assign ch_data_ok = resp;
   assign ch_rdata   = (vld_q[LATENCY-1] && !twr_q[LATENCY-1]) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_sramx_arbiter.sv
// tb/tb_sramx_arbiter.sv - directed bench for sramx_arbiter
// Three instances cover LATENCY 1/4/3 and translation on/off.
module tb_sramx_arbiter;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic [1:0]  a_req, b_req, d_req;
   logic [7:0]  a_wen, b_wen, d_wen;
   logic [63:0] a_addr, b_addr, d_addr, a_wd, b_wd, d_wd;
   logic [1:0]  a_aok, b_aok, d_aok, a_dok, b_dok, d_dok;
   logic [31:0] a_rd, b_rd, d_rd, a_mrd, b_mrd, d_mrd;
   logic        a_men, b_men, d_men;
   logic [3:0]  a_mwen, b_mwen, d_mwen;
   logic [31:0] a_maddr, b_maddr, d_maddr, a_mwd, b_mwd, d_mwd;

   int total = 0;
   int bad   = 0;

   sramx_arbiter #(.NCH(2), .LATENCY(1), .MAX_OUT(2), .ADDR_TRANS(1)) u_a (
      .clk(clk), .resetn(resetn), .ch_req(a_req), .ch_wen(a_wen), .ch_addr(a_addr),
      .ch_wdata(a_wd), .ch_addr_ok(a_aok), .ch_data_ok(a_dok), .ch_rdata(a_rd),
      .mem_en(a_men), .mem_wen(a_mwen), .mem_addr(a_maddr), .mem_wdata(a_mwd), .mem_rdata(a_mrd));

   sramx_arbiter #(.NCH(2), .LATENCY(4), .MAX_OUT(2), .ADDR_TRANS(1)) u_b (
      .clk(clk), .resetn(resetn), .ch_req(b_req), .ch_wen(b_wen), .ch_addr(b_addr),
      .ch_wdata(b_wd), .ch_addr_ok(b_aok), .ch_data_ok(b_dok), .ch_rdata(b_rd),
      .mem_en(b_men), .mem_wen(b_mwen), .mem_addr(b_maddr), .mem_wdata(b_mwd), .mem_rdata(b_mrd));

   sramx_arbiter #(.NCH(2), .LATENCY(3), .MAX_OUT(2), .ADDR_TRANS(0)) u_d (
      .clk(clk), .resetn(resetn), .ch_req(d_req), .ch_wen(d_wen), .ch_addr(d_addr),
      .ch_wdata(d_wd), .ch_addr_ok(d_aok), .ch_data_ok(d_dok), .ch_rdata(d_rd),
      .mem_en(d_men), .mem_wen(d_mwen), .mem_addr(d_maddr), .mem_wdata(d_mwd), .mem_rdata(d_mrd));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] t3_aok [6] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10};
   logic [1:0] t3_dok [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      a_req = '0; b_req = '0; d_req = '0;
      a_wen = '0; b_wen = '0; d_wen = '0;
      a_addr = '0; b_addr = '0; d_addr = '0;
      a_wd = '0; b_wd = '0; d_wd = '0;
      a_mrd = '0; b_mrd = '0; d_mrd = '0;
      step(); step();

      // reset state: outputs low even with a request present
      a_req = 2'b01; a_addr[31:0] = 32'hBFC0_0000; #1;
      chk("rst_mem_en", {31'b0, a_men}, 32'h0);
      chk("rst_addr_ok", {30'b0, a_aok}, 32'h0);
      chk("rst_data_ok", {30'b0, a_dok}, 32'h0);
      chk("rst_rdata", a_rd, 32'h0);
      a_req = '0; resetn = 1'b1;

      // T1 single read
      step(); a_req = 2'b01; a_addr[31:0] = 32'hBFC0_0000; #1;
      chk("t1_mem_addr", a_maddr, 32'h1FC0_0000);
      chk("t1_addr_ok", {30'b0, a_aok}, 32'h1);
      chk("t1_mem_en", {31'b0, a_men}, 32'h1);
      step(); a_req = '0; a_mrd = 32'h2408_0001; #1;
      chk("t1_data_ok", {30'b0, a_dok}, 32'h1);
      chk("t1_rdata", a_rd, 32'h2408_0001);
      chk("t1_idle_en", {31'b0, a_men}, 32'h0);
      chk("t1_idle_addr", a_maddr, 32'h0);

      // T4 write from ch1 (also returns rr_ptr to 0)
      step(); a_req = 2'b10; a_wen[7:4] = 4'b0011; a_addr[63:32] = 32'h8000_0010;
      a_wd[63:32] = 32'hDEAD_BEEF; a_mrd = 32'h1234_5678; #1;
      chk("t4_mem_wen", {28'b0, a_mwen}, 32'h3);
      chk("t4_mem_addr", a_maddr, 32'h0000_0010);
      chk("t4_mem_wdata", a_mwd, 32'hDEAD_BEEF);
      chk("t4_addr_ok", {30'b0, a_aok}, 32'h2);
      step(); a_req = '0; a_wen = '0; #1;
      chk("t4_data_ok", {30'b0, a_dok}, 32'h2);
      chk("t4_rdata", a_rd, 32'h0);

      // T2 contention alternates 0,1,0,1
      a_addr[31:0] = 32'h0000_0100; a_addr[63:32] = 32'h0000_0200;
      for (int c = 0; c < 4; c++) begin
         step(); a_req = 2'b11; a_mrd = 32'hA000_0000 + c; #1;
         chk("t2_addr_ok", {30'b0, a_aok}, 32'h1 << (c % 2));
         if (c > 0) begin
            chk("t2_data_ok", {30'b0, a_dok}, 32'h1 << ((c - 1) % 2));
            chk("t2_rdata", a_rd, 32'hA000_0000 + c);
         end
      end
      step(); a_req = '0; a_mrd = 32'hA000_0004; #1;
      chk("t2_last_data_ok", {30'b0, a_dok}, 32'h2);
      chk("t2_last_rdata", a_rd, 32'hA000_0004);

      // T5 untranslated regions, and translation disabled
      step(); a_req = 2'b01; a_addr[31:0] = 32'h0040_0000;
      d_req = 2'b01; d_addr[31:0] = 32'h9FC0_0000; #1;
      chk("t5_useg", a_maddr, 32'h0040_0000);
      chk("t5_notrans", d_maddr, 32'h9FC0_0000);
      step(); a_addr[31:0] = 32'hC000_0000; d_req = '0; #1;
      chk("t5_kseg2", a_maddr, 32'hC000_0000);
      step(); a_req = '0;

      // T3 outstanding limit on ch1, LATENCY 4
      for (int c = 0; c < 6; c++) begin
         step(); b_req = 2'b10; b_addr[63:32] = 32'h0000_0040; b_mrd = 32'hB000_0000 + c; #1;
         chk("t3_addr_ok", {30'b0, b_aok}, {30'b0, t3_aok[c]});
         chk("t3_data_ok", {30'b0, b_dok}, {30'b0, t3_dok[c]});
         chk("t3_rdata", b_rd, (t3_dok[c] != 2'b00) ? 32'hB000_0000 + c : 32'h0);
      end
      step(); b_req = '0;

      // T6 async reset with two reads in flight, LATENCY 3
      step(); d_req = 2'b01; d_addr[31:0] = 32'h0000_1000; d_mrd = 32'h5555_AAAA; #1;
      chk("t6_grant0", {30'b0, d_aok}, 32'h1);
      step(); d_addr[31:0] = 32'h0000_1004; #1;
      chk("t6_grant1", {30'b0, d_aok}, 32'h1);
      step(); d_req = '0;
      step(); d_req = 2'b01; #1;
      chk("t6_pre_data_ok", {30'b0, d_dok}, 32'h1);
      resetn = 1'b0; #1;
      chk("t6_rst_data_ok", {30'b0, d_dok}, 32'h0);
      chk("t6_rst_rdata", d_rd, 32'h0);
      chk("t6_rst_mem_en", {31'b0, d_men}, 32'h0);
      resetn = 1'b1; d_req = '0;
      for (int c = 0; c < 3; c++) begin
         step(); #1;
         chk("t6_post_data_ok", {30'b0, d_dok}, 32'h0);
      end
      step(); d_req = 2'b01; #1;
      chk("t6_regrant0", {30'b0, d_aok}, 32'h1);
      step(); #1;
      chk("t6_regrant1", {30'b0, d_aok}, 32'h1);
      step(); d_req = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
